// File: rtl/tx_rf_switch_seq_pkg.sv
// -----------------------------------------------------------------------------
// tx_rf_switch_seq_pkg
// Shared definitions for the TX RF front-end switch sequencer:
//   - seq_state_e : FSM state encoding (also exported on the seq_state port)
//   - rf_ctrl_t   : bundle of the four front-end control levels
//   - decode_ctrl : maps a state to its front-end control levels
// -----------------------------------------------------------------------------
package tx_rf_switch_seq_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef enum logic [SEQ_STATE_W-1:0] {
        SEQ_IDLE_RX  = 3'd0,
        SEQ_TR_SET   = 3'd1,
        SEQ_PA_ON    = 3'd2,
        SEQ_PA_OFF   = 3'd3,
        SEQ_RX_GUARD = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic tr;     // T/R switch in TX position
        logic pa;     // PA enable
        logic lna;    // LNA enable
        logic blank;  // RX AGC / energy-detect blanking
    } rf_ctrl_t;

    // Front-end levels per state. Any unknown encoding maps to the safe RX
    // posture (PA off, switch at RX) so a corrupted state can never key the PA.
    function automatic rf_ctrl_t decode_ctrl(input seq_state_e st);
        rf_ctrl_t c;
        case (st)
            SEQ_IDLE_RX:  c = '{tr: 1'b0, pa: 1'b0, lna: 1'b1, blank: 1'b0};
            SEQ_TR_SET:   c = '{tr: 1'b1, pa: 1'b0, lna: 1'b0, blank: 1'b1};
            SEQ_PA_ON:    c = '{tr: 1'b1, pa: 1'b1, lna: 1'b0, blank: 1'b1};
            SEQ_PA_OFF:   c = '{tr: 1'b1, pa: 1'b0, lna: 1'b0, blank: 1'b1};
            SEQ_RX_GUARD: c = '{tr: 1'b0, pa: 1'b0, lna: 1'b1, blank: 1'b1};
            default:      c = '{tr: 1'b0, pa: 1'b0, lna: 1'b1, blank: 1'b0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/tx_rf_switch_seq.sv
// -----------------------------------------------------------------------------
// tx_rf_switch_seq
// Turns the TX on-detection flags into timed RF front-end controls: the T/R
// switch settles before the PA turns on, the PA drops before the switch goes
// back to RX, and RX AGC / energy detect stays blanked for a guard time.
//
// Ports
//   clk                 in   system clock
//   rstn                in   asynchronous active-low reset
//   pa_lead_count_top   in   [CNT_W]  cycles-1 from switch-to-TX until PA on
//   tr_lag_count_top    in   [CNT_W]  cycles-1 from PA off until switch to RX
//   rx_guard_count_top  in   [CNT_W]  cycles-1 of RX blanking after switch-back
//   tx_bb_is_ongoing    in   baseband TX active (extended)
//   tx_rf_is_ongoing    in   RF TX active (delay-compensated)
//   force_rx            in   software override: abort TX sequencing, hold RX
//   tr_switch_tx        out  1 = T/R switch in TX position
//   pa_enable           out  power amplifier enable
//   lna_enable          out  LNA enable (0 while transmitting)
//   rx_blank            out  1 = RX AGC / energy detect must ignore samples
//   pa_wdog_err         out  one-cycle pulse: PA-on watchdog expired
//   seq_state           out  [3] current FSM state (debug)
//
// All outputs are registered and decoded from the next state, so a control
// level changes on the same edge the FSM changes state.
// -----------------------------------------------------------------------------
module tx_rf_switch_seq
    import tx_rf_switch_seq_pkg::*;
#(
    parameter int unsigned         CNT_W    = 10,
    parameter int unsigned         WDOG_W   = 20,
    parameter logic [WDOG_W-1:0]   WDOG_TOP = {WDOG_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [CNT_W-1:0]       pa_lead_count_top,
    input  logic [CNT_W-1:0]       tr_lag_count_top,
    input  logic [CNT_W-1:0]       rx_guard_count_top,
    input  logic                   tx_bb_is_ongoing,
    input  logic                   tx_rf_is_ongoing,
    input  logic                   force_rx,
    output logic                   tr_switch_tx,
    output logic                   pa_enable,
    output logic                   lna_enable,
    output logic                   rx_blank,
    output logic                   pa_wdog_err,
    output logic [SEQ_STATE_W-1:0] seq_state
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [WDOG_W-1:0] WDOG_ONE = {{(WDOG_W-1){1'b0}}, 1'b1};

    seq_state_e        state_r;
    seq_state_e        state_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [WDOG_W-1:0] wdog_r;
    logic              rf_seen_r;
    logic              cnt_sat_s;
    logic              wdog_exp_s;
    logic              tx_req_s;
    logic              tx_gone_s;
    rf_ctrl_t          ctrl_nx_s;
    logic              tr_r;
    logic              pa_r;
    logic              lna_r;
    logic              blank_r;
    logic              wdog_err_r;

    // A saturated counter ends the phase even if the top port was lowered
    // below the running count, so a timed phase can never stall forever.
    assign cnt_sat_s = (cnt_r == CNT_MAX);
    assign tx_req_s  = tx_bb_is_ongoing && !force_rx;
    assign tx_gone_s = !tx_bb_is_ongoing && !tx_rf_is_ongoing;

    // Next-state logic. In TR_SET an abort wins over the lead timeout so the
    // PA is never keyed for a burst that has already gone away.
    always_comb begin
        state_nx_s = state_r;
        wdog_exp_s = 1'b0;
        case (state_r)
            SEQ_IDLE_RX: begin
                if (tx_req_s) begin
                    state_nx_s = SEQ_TR_SET;
                end else begin
                    state_nx_s = SEQ_IDLE_RX;
                end
            end
            SEQ_TR_SET: begin
                if (force_rx || tx_gone_s) begin
                    state_nx_s = SEQ_RX_GUARD;
                end else if ((cnt_r == pa_lead_count_top) || cnt_sat_s) begin
                    state_nx_s = SEQ_PA_ON;
                end else begin
                    state_nx_s = SEQ_TR_SET;
                end
            end
            SEQ_PA_ON: begin
                if (wdog_r == WDOG_TOP) begin
                    state_nx_s = SEQ_PA_OFF;
                    wdog_exp_s = 1'b1;
                end else if (force_rx) begin
                    state_nx_s = SEQ_PA_OFF;
                end else if ((rf_seen_r && !tx_rf_is_ongoing) || tx_gone_s) begin
                    state_nx_s = SEQ_PA_OFF;
                end else begin
                    state_nx_s = SEQ_PA_ON;
                end
            end
            SEQ_PA_OFF: begin
                if ((cnt_r == tr_lag_count_top) || cnt_sat_s) begin
                    state_nx_s = SEQ_RX_GUARD;
                end else begin
                    state_nx_s = SEQ_PA_OFF;
                end
            end
            SEQ_RX_GUARD: begin
                if (tx_req_s) begin
                    state_nx_s = SEQ_TR_SET;
                end else if ((cnt_r == rx_guard_count_top) || cnt_sat_s) begin
                    state_nx_s = SEQ_IDLE_RX;
                end else begin
                    state_nx_s = SEQ_RX_GUARD;
                end
            end
            default: begin
                state_nx_s = SEQ_IDLE_RX;
            end
        endcase
    end

    assign ctrl_nx_s = decode_ctrl(state_nx_s);

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= SEQ_IDLE_RX;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Phase counter: cleared on every state change, saturating otherwise.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r <= '0;
        end else if (state_nx_s != state_r) begin
            cnt_r <= '0;
        end else if (!cnt_sat_s) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // PA-on watchdog: runs only while staying in PA_ON, saturates at its top.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_r <= '0;
        end else if ((state_r == SEQ_PA_ON) && (state_nx_s == SEQ_PA_ON)) begin
            if (wdog_r != WDOG_TOP) begin
                wdog_r <= wdog_r + WDOG_ONE;
            end else begin
                wdog_r <= wdog_r;
            end
        end else begin
            wdog_r <= '0;
        end
    end

    // rf_seen: arms the "RF burst finished" exit once RF activity is observed.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_seen_r <= 1'b0;
        end else if ((state_nx_s == SEQ_TR_SET) && (state_r != SEQ_TR_SET)) begin
            rf_seen_r <= 1'b0;
        end else if ((state_r == SEQ_PA_ON) && tx_rf_is_ongoing) begin
            rf_seen_r <= 1'b1;
        end else begin
            rf_seen_r <= rf_seen_r;
        end
    end

    // Registered front-end controls, taken from the next-state decode.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tr_r       <= 1'b0;
            pa_r       <= 1'b0;
            lna_r      <= 1'b1;
            blank_r    <= 1'b0;
            wdog_err_r <= 1'b0;
        end else begin
            tr_r       <= ctrl_nx_s.tr;
            pa_r       <= ctrl_nx_s.pa;
            lna_r      <= ctrl_nx_s.lna;
            blank_r    <= ctrl_nx_s.blank;
            wdog_err_r <= wdog_exp_s;
        end
    end

    assign tr_switch_tx = tr_r;
    assign pa_enable    = pa_r;
    assign lna_enable   = lna_r;
    assign rx_blank     = blank_r;
    assign pa_wdog_err  = wdog_err_r;
    assign seq_state    = state_r;

endmodule
